vx_tcu_drl_f8_sched: RTL



---
 rtl/vx_tcu_drl_f8_sched.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/vx_tcu_drl_f8_sched.sv
// Beat sequencer for the FP8/BF8 FEDP multiply lanes.
// Splits one dot-product request into beats of N words per operand.
// Each beat carries its element valid mask, first/last framing and tag.
// A credit counter, returned through done_in, limits requests in flight.
// Optional: define TCU_F8_ZSKIP_EN to skip non-final beats in which every
// valid element pair has a zero operand.
module vx_tcu_drl_f8_sched #(
    parameter int unsigned N       = 2,
    parameter int unsigned K_WORDS = 8,
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned MASK_W  = 8 * N,
    parameter int unsigned LEN_W   = $clog2(4 * K_WORDS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [31:0]            req_id,
    input  logic [2:0]             req_fmt,
    input  logic [LEN_W-1:0]       req_len,
    input  logic [K_WORDS*32-1:0]  req_a,
    input  logic [K_WORDS*32-1:0]  req_b,
    output logic                   dp_valid,
    input  logic                   dp_ready,
    output logic [31:0]            dp_req_id,
    output logic [2:0]             dp_fmt,
    output logic [N*32-1:0]        dp_a_row,
    output logic [N*32-1:0]        dp_b_col,
    output logic [MASK_W-1:0]      dp_vld_mask,
    output logic                   dp_first,
    output logic                   dp_last,
    input  logic                   done_in,
    output logic                   busy
);

    localparam int unsigned EPB        = 4 * N;
    localparam int unsigned WB         = 32 * N;
    localparam int unsigned NBEATS_MAX = K_WORDS / N;
    localparam int unsigned BEAT_W     = (NBEATS_MAX > 1) ? $clog2(NBEATS_MAX) : 1;
    localparam int unsigned CRED_W     = $clog2(MAX_OUT + 1);

    typedef enum logic [0:0] {IDLE, ISSUE} state_t;

    state_t                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d, ld_beat;
    logic [CRED_W-1:0]      credits_q, credits_d;
    logic [LEN_W-1:0]       len_q;
    logic [31:0]            id_q;
    logic [2:0]             fmt_q;
    logic [K_WORDS*32-1:0]  a_q, b_q;

    logic                   accept, load, last_hs, ld_first;
    logic [LEN_W-1:0]       src_len;
    logic [31:0]            src_id;
    logic [2:0]             src_fmt;
    logic [K_WORDS*32-1:0]  src_a, src_b;
    int unsigned            len_u, beat_u, nb;
    logic                   ld_last, ld_valid;
    logic [WB-1:0]          ld_a, ld_b;
    logic [MASK_W-1:0]      ld_mask;
`ifdef TCU_F8_ZSKIP_EN
    logic                   all_zero;
`endif

    logic                   dp_valid_d, dp_first_d, dp_last_d, req_ready_d, busy_d;
    logic [31:0]            dp_req_id_d;
    logic [2:0]             dp_fmt_d;
    logic [N*32-1:0]        dp_a_row_d, dp_b_col_d;
    logic [MASK_W-1:0]      dp_vld_mask_d;

    // Next-state, next-beat contents and credit bookkeeping
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        credits_d     = credits_q;
        dp_valid_d    = dp_valid;
        dp_first_d    = dp_first;
        dp_last_d     = dp_last;
        dp_req_id_d   = dp_req_id;
        dp_fmt_d      = dp_fmt;
        dp_a_row_d    = dp_a_row;
        dp_b_col_d    = dp_b_col;
        dp_vld_mask_d = dp_vld_mask;
        accept        = 1'b0;
        load          = 1'b0;
        last_hs       = 1'b0;
        ld_first      = 1'b0;
        ld_beat       = beat_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept   = 1'b1;
                    load     = 1'b1;
                    ld_beat  = '0;
                    ld_first = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // a presented beat waits for dp_ready; a skipped beat (dp_valid=0) advances at once
                if (!dp_valid || dp_ready) begin
                    if (dp_valid && dp_last) begin
                        last_hs       = 1'b1;
                        state_d       = IDLE;
                        beat_d        = '0;
                        dp_valid_d    = 1'b0;
                        dp_first_d    = 1'b0;
                        dp_last_d     = 1'b0;
                        dp_req_id_d   = '0;
                        dp_fmt_d      = '0;
                        dp_a_row_d    = '0;
                        dp_b_col_d    = '0;
                        dp_vld_mask_d = '0;
                    end else begin
                        load     = 1'b1;
                        ld_beat  = beat_q + BEAT_W'(1);
                        ld_first = dp_valid ? 1'b0 : dp_first;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // beat source: live request on acceptance, latched copy afterwards
        src_len = accept ? req_len : len_q;
        src_id  = accept ? req_id  : id_q;
        src_fmt = accept ? req_fmt : fmt_q;
        src_a   = accept ? req_a   : a_q;
        src_b   = accept ? req_b   : b_q;

        len_u  = 32'(src_len);
        beat_u = 32'(ld_beat);
        nb     = (len_u + EPB - 1) / EPB;
        if (nb == 0) nb = 1;
        ld_last = (beat_u == nb - 1);
        ld_a    = src_a[beat_u*WB +: WB];
        ld_b    = src_b[beat_u*WB +: WB];
        ld_mask = '0;
        for (int unsigned e = 0; e < EPB; e++) begin
            if (beat_u * EPB + e < len_u) ld_mask[2*e] = 1'b1;
        end
`ifdef TCU_F8_ZSKIP_EN
        // E4M3 and E5M2 both hold exponent+mantissa in [6:0]; sign is ignored
        all_zero = 1'b1;
        for (int unsigned e = 0; e < EPB; e++) begin
            if (ld_mask[2*e] && (ld_a[8*e +: 7] != 7'd0) && (ld_b[8*e +: 7] != 7'd0))
                all_zero = 1'b0;
        end
        ld_valid = ld_last || !all_zero;
`else
        ld_valid = 1'b1;
`endif

        if (load) begin
            beat_d        = ld_beat;
            dp_valid_d    = ld_valid;
            dp_first_d    = ld_first;
            dp_last_d     = ld_last;
            dp_req_id_d   = src_id;
            dp_fmt_d      = src_fmt;
            dp_a_row_d    = ld_a;
            dp_b_col_d    = ld_b;
            dp_vld_mask_d = ld_mask;
        end

        // a return coinciding with a completion leaves the count unchanged
        if (last_hs && !done_in)
            credits_d = credits_q + CRED_W'(1);
        else if (!last_hs && done_in && (credits_q != '0))
            credits_d = credits_q - CRED_W'(1);

        req_ready_d = (state_d == IDLE) && (credits_d < CRED_W'(MAX_OUT));
        busy_d      = (state_d != IDLE) || (credits_d != '0);
    end

    // State, latched request and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            credits_q   <= '0;
            len_q       <= '0;
            id_q        <= '0;
            fmt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            dp_valid    <= 1'b0;
            dp_first    <= 1'b0;
            dp_last     <= 1'b0;
            dp_req_id   <= '0;
            dp_fmt      <= '0;
            dp_a_row    <= '0;
            dp_b_col    <= '0;
            dp_vld_mask <= '0;
        end else begin
            assert (!(done_in && (credits_q == '0)))
                else $error("vx_tcu_drl_f8_sched: done_in with no credits outstanding");
            state_q     <= state_d;
            beat_q      <= beat_d;
            credits_q   <= credits_d;
            req_ready   <= req_ready_d;
            busy        <= busy_d;
            dp_valid    <= dp_valid_d;
            dp_first    <= dp_first_d;
            dp_last     <= dp_last_d;
            dp_req_id   <= dp_req_id_d;
            dp_fmt      <= dp_fmt_d;
            dp_a_row    <= dp_a_row_d;
            dp_b_col    <= dp_b_col_d;
            dp_vld_mask <= dp_vld_mask_d;
            if (accept) begin
                len_q <= req_len;
                id_q  <= req_id;
                fmt_q <= req_fmt;
                a_q   <= req_a;
                b_q   <= req_b;
            end
        end
    end

endmodule
